spi_tx_arbiter: RTL and testbench

- Shares one SPI byte transmitter between NREQ requesters using round-robin arbitration.
- Each requester has a one-byte holding register with a valid/ready handshake.
- Drives the transmitter's hold-valid-until-done protocol: tx_valid is held until tx_done rises, dropped, then tx_done must fall.
- A watchdog aborts transactions the transmitter never completes; the block sits between host-side byte producers and the SPI transmitter.

---
 rtl/spi_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI byte transmitter between NREQ requesters,
// with per-requester holding registers, a completion handshake and a timeout watchdog.
module spi_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int TIMEOUT   = 4096,
    parameter int DRAIN_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_done,
    output logic [NREQ-1:0]      done_pulse,
    output logic [NREQ-1:0]      err_pulse,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    localparam int TMAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [2:0] {IDLE, SEND, RELEASE, ABORT, DRAIN} state_t;

    state_t            state, state_d;
    logic [TW-1:0]     timer, timer_d;
    logic              tx_valid_d;
    logic [7:0]        tx_data_d;
    logic [IDW-1:0]    grant_d;
    logic [IDW-1:0]    last, last_d;
    logic [NREQ-1:0]   done_d, err_d, clr_mask;
    logic [NREQ-1:0]   hold_valid;
    logic [7:0]        hold_data [NREQ];
    logic [IDW-1:0]    winner;
    logic              done_m, done_s;

    assign req_ready = ~hold_valid;
    assign busy      = (state != IDLE);

    // tx_done comes from the divided SPI clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_m <= 1'b0;
            done_s <= 1'b0;
        end else begin
            done_m <= tx_done;
            done_s <= done_m;
        end
    end

    // NOTE: hold_data is only meaningful while hold_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= req_data[8*i +: 8];
                end else if (clr_mask[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    // First pending requester after last, wrapping around.
    always_comb begin
        logic found;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int cand;
            cand = (int'(last) + k) % NREQ;
            if (!found && hold_valid[cand]) begin
                winner = IDW'(cand);
                found  = 1'b1;
            end
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        timer_d    = timer;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        grant_d    = grant_id;
        last_d     = last;
        done_d     = '0;
        err_d      = '0;
        clr_mask   = '0;
        case (state)
            IDLE: begin
                if (|hold_valid) begin
                    grant_d    = winner;
                    tx_data_d  = hold_data[winner];
                    tx_valid_d = 1'b1;
                    timer_d    = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                timer_d = timer + 1'b1;
                // The first two SEND cycles ignore a done_s left over from the previous byte.
                if (done_s && timer >= TW'(2)) begin
                    tx_valid_d = 1'b0;
                    timer_d    = '0;
                    state_d    = RELEASE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    tx_valid_d = 1'b0;
                    state_d    = ABORT;
                end
            end
            RELEASE: begin
                timer_d = timer + 1'b1;
                if (!done_s) begin
                    done_d   = ONE << grant_id;
                    clr_mask = ONE << grant_id;
                    last_d   = grant_id;
                    state_d  = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                err_d    = ONE << grant_id;
                clr_mask = ONE << grant_id;
                last_d   = grant_id;
                timer_d  = '0;
                state_d  = DRAIN;
            end
            DRAIN: begin
                timer_d = timer + 1'b1;
                if (timer == TW'(DRAIN_CYC - 1)) begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            last       <= IDW'(NREQ - 1);
            done_pulse <= '0;
            err_pulse  <= '0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            tx_valid   <= tx_valid_d;
            tx_data    <= tx_data_d;
            grant_id   <= grant_d;
            last       <= last_d;
            done_pulse <= done_d;
            err_pulse  <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: directed and random phases scored
// against a round-robin service-order model.
module tb_spi_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int IDW       = 2;
    localparam int TIMEOUT   = 64;
    localparam int DRAIN_CYC = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [8*NREQ-1:0]    req_data;
    logic [NREQ-1:0]      req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_done;
    logic [NREQ-1:0]      done_pulse;
    logic [NREQ-1:0]      err_pulse;
    logic                 busy;
    logic [IDW-1:0]       grant_id;

    spi_tx_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_done(tx_done), .done_pulse(done_pulse), .err_pulse(err_pulse),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     data;
    } grant_t;

    grant_t grant_q[$], exp_q[$];
    int     done_q[$], err_q[$], exp_done[$], exp_err[$];
    int     total = 0;
    int     bad = 0;

    logic       pend_valid [NREQ];
    logic [7:0] pend_data  [NREQ];
    int         last;

    // Monitor: logs grants and pulses, tracks tx_valid high/low run lengths.
    logic   prev_valid = 1'b0;
    int     high_cnt = 0, low_cnt = 0, last_high = 0, last_gap = 0, unstable = 0;
    grant_t cap;

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (done_pulse[i] === 1'b1) done_q.push_back(i);
            if (err_pulse[i] === 1'b1) err_q.push_back(i);
        end
        if (tx_valid === 1'b1) begin
            if (!prev_valid) begin
                grant_q.push_back(grant_t'({grant_id, tx_data}));
                cap      <= grant_t'({grant_id, tx_data});
                last_gap <= low_cnt;
                high_cnt <= 1;
            end else begin
                if (cap.id !== grant_id || cap.data !== tx_data) unstable <= unstable + 1;
                high_cnt <= high_cnt + 1;
            end
        end else begin
            if (prev_valid) begin
                last_high <= high_cnt;
                low_cnt   <= 1;
            end else begin
                low_cnt <= low_cnt + 1;
            end
        end
        prev_valid <= (tx_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (pend_valid[c]) return c;
        end
        return -1;
    endfunction

    // Every pending byte gets served in round-robin order from last+1.
    task automatic model_drain();
        int w;
        w = rr_pick();
        while (w >= 0) begin
            exp_q.push_back(grant_t'({IDW'(w), pend_data[w]}));
            exp_done.push_back(w);
            pend_valid[w] = 1'b0;
            last = w;
            w = rr_pick();
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) pend_valid[i] = 1'b0;
        last = NREQ - 1;
        grant_q.delete(); exp_q.delete();
        done_q.delete(); err_q.delete(); exp_done.delete(); exp_err.delete();
    endtask

    task automatic compare_phase(input string tag);
        check({tag, "_ngrant"}, grant_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < grant_q.size(); k++) begin
            check({tag, "_gid"}, grant_q[k].id, exp_q[k].id);
            check({tag, "_gdata"}, grant_q[k].data, exp_q[k].data);
        end
        check({tag, "_ndone"}, done_q.size(), exp_done.size());
        for (int k = 0; k < exp_done.size() && k < done_q.size(); k++)
            check({tag, "_done_id"}, done_q[k], exp_done[k]);
        check({tag, "_nerr"}, err_q.size(), exp_err.size());
        for (int k = 0; k < exp_err.size() && k < err_q.size(); k++)
            check({tag, "_err_id"}, err_q[k], exp_err[k]);
        grant_q.delete(); exp_q.delete();
        done_q.delete(); err_q.delete(); exp_done.delete(); exp_err.delete();
    endtask

    task automatic load(input logic [NREQ-1:0] mask, input logic [8*NREQ-1:0] bytes);
        req_data  = bytes;
        req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                pend_valid[i] = 1'b1;
                pend_data[i]  = bytes[8*i +: 8];
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic wait_valid(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (tx_valid !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, tx_valid, lvl);
    endtask

    // Transmitter stub: raise tx_done rise cycles after tx_valid, drop it fall cycles after release.
    task automatic serve(input int rise, input int fall);
        wait_valid(1'b1, 400, "serve_rise");
        repeat (rise) @(negedge clk);
        tx_done = 1'b1;
        wait_valid(1'b0, 200, "serve_fall");
        repeat (fall) @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*NREQ-1:0] bytes;
        logic [NREQ-1:0]   mask;
        int                cnt;
        int                n;

        rst = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, '0);
        check("rst_req_ready", req_ready, {NREQ{1'b1}});
        check("rst_done_pulse", done_pulse, '0);
        check("rst_err_pulse", err_pulse, '0);
        rst = 1'b0;
        @(negedge clk);
        model_reset();

        // Single byte from requester 2, two-cycle accept-to-tx_valid latency.
        bytes = '0;
        bytes[23:16] = 8'hA5;
        load(4'b0100, bytes);
        check("lat1_tx_valid", tx_valid, 1'b0);
        check("lat1_ready2", req_ready[2], 1'b0);
        @(negedge clk);
        check("lat2_tx_valid", tx_valid, 1'b1);
        check("single_grant_id", grant_id, 2);
        check("single_tx_data", tx_data, 8'hA5);
        serve(40, 10);
        wait_idle();
        check("single_ready2", req_ready[2], 1'b1);
        model_drain();
        compare_phase("single");

        // All four pending right after reset, then requesters 1 and 3.
        do_reset();
        load(4'b1111, 32'h13121110);
        for (int k = 0; k < 4; k++) serve($urandom_range(0, 20), $urandom_range(0, 8));
        wait_idle();
        model_drain();
        compare_phase("rr_all");
        bytes = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        load(4'b1010, bytes);
        for (int k = 0; k < 2; k++) serve($urandom_range(0, 20), $urandom_range(0, 8));
        wait_idle();
        model_drain();
        compare_phase("rr_13");

        // Random subsets and transmitter timing.
        for (int r = 0; r < 8; r++) begin
            mask  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            bytes = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            cnt   = $countones(mask);
            load(mask, bytes);
            for (int k = 0; k < cnt; k++) serve($urandom_range(0, 30), $urandom_range(0, 12));
            wait_idle();
            model_drain();
            compare_phase("rand");
        end

        // Stale tx_done around the second grant must not complete it.
        bytes = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        load(4'b0101, bytes);
        serve(8, 4);
        n = 0;
        while (done_pulse === '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stale_first_done", (done_pulse !== '0), 1'b1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stale_second_granted", tx_valid, 1'b1);
        repeat (20) @(negedge clk);
        check("stale_still_sending", tx_valid, 1'b1);
        check("stale_no_extra_done", done_q.size(), 1);
        serve(5, 3);
        wait_idle();
        model_drain();
        compare_phase("stale");

        // Timeout: first winner is never completed, second is served after DRAIN.
        bytes = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        load(4'b1001, bytes);
        wait_valid(1'b1, 10, "to_rise");
        wait_valid(1'b0, 200, "to_fall");
        @(negedge clk);
        check("to_high_len", last_high, TIMEOUT);
        repeat (10) @(negedge clk);
        check("to_drain_busy", busy, 1'b1);
        check("to_drain_low", tx_valid, 1'b0);
        check("to_err_seen", err_q.size(), 1);
        serve(6, 2);
        wait_idle();
        check("to_drain_gap", last_gap, DRAIN_CYC + 2);
        model_drain();
        exp_err.push_back(exp_done.pop_front());
        compare_phase("timeout");

        // Reset while SEND is active with three bytes pending.
        bytes = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        load(4'b1110, bytes);
        wait_valid(1'b1, 10, "mid_rise");
        rst = 1'b1;
        @(negedge clk);
        check("mid_tx_valid", tx_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_req_ready", req_ready, {NREQ{1'b1}});
        check("mid_done_pulse", done_pulse, '0);
        check("mid_err_pulse", err_pulse, '0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_after_tx_valid", tx_valid, 1'b0);
        check("mid_after_busy", busy, 1'b0);
        model_reset();

        // Requester 0 streams three bytes with req_valid held high.
        fork
            begin
                int m;
                for (int k = 0; k < 3; k++) begin
                    req_data[7:0] = 8'(k + 1);
                    req_valid[0]  = 1'b1;
                    m = 0;
                    while (req_ready[0] !== 1'b1 && m < 500) begin
                        @(negedge clk);
                        m++;
                    end
                    check("b2b_ready", req_ready[0], 1'b1);
                    if (k > 0) check("b2b_after_done", done_pulse[0], 1'b1);
                    pend_valid[0] = 1'b1;
                    pend_data[0]  = 8'(k + 1);
                    model_drain();
                    @(negedge clk);
                end
                req_valid[0] = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) serve($urandom_range(0, 15), $urandom_range(0, 6));
            end
        join
        wait_idle();
        compare_phase("b2b");

        check("tx_hold_stable", unstable, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
